// File: rtl/calc1_pkg.sv
// calc1_pkg: definitions shared across the calc1 datapath.
//   - response codes driven on the requester interface
//   - output FSM state type used by resp_drvreg
//   - odd_par(): odd parity over a {resp, data} pair (used when RESP_PARITY_EN is defined)
package calc1_pkg;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b10;
  localparam logic [1:0] RESP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WAIT  = 2'd2
  } drv_state_e;

  // The returned bit makes the total number of ones across {resp, data, par} odd.
  // For all-zero input it therefore returns 1.
  function automatic logic odd_par(input logic [1:0] resp, input logic [31:0] data);
    return ~(^{resp, data});
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// resp_fifo: storage for pending {resp, data} responses.
// State changes on the falling edge of i_clk. i_rst is a synchronous,
// active-high flush.
//
// Ports:
//   i_clk, i_rst         clock (falling-edge) / synchronous flush
//   i_push, i_resp, i_data
//                        write one entry; the write is ignored when the FIFO is full
//   i_pop                advance the head; ignored when the FIFO is empty
//   o_resp, o_data       head entry (combinational read at the read pointer)
//   o_full, o_empty      status, taken from the registered count
//   o_cnt                occupancy, 0..DEPTH
module resp_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_push,
  input  logic [1:0]  i_resp,
  input  logic [31:0] i_data,
  input  logic        i_pop,
  output logic [1:0]  o_resp,
  output logic [31:0] o_data,
  output logic        o_full,
  output logic        o_empty,
  output logic [4:0]  o_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [33:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [4:0]    r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == 5'(DEPTH));
  assign o_empty = (r_cnt == 5'd0);
  assign o_cnt   = r_cnt;

  // Full and empty are based on the count at the start of the cycle. A pop in
  // the same cycle does not make room for a push in that cycle.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  assign {o_resp, o_data} = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so the pointers wrap without extra logic.
  always_ff @(negedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= 5'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 5'd1;
        2'b01:   r_cnt <= r_cnt - 5'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // The storage array has no reset. Resetting the pointers is enough to flush it.
  always_ff @(negedge i_clk) begin
    if (w_push && !i_rst) r_mem[r_wr_ptr] <= {i_resp, i_data};
  end

endmodule

// File: rtl/resp_drvreg.sv
// resp_drvreg: per-port response driver. Queues completed results and
// presents each one as a single-cycle out_resp/out_data pulse, in arrival
// order. Consecutive pulses are separated by GAP idle cycles.
// Every register changes on the falling edge of c_clk.
//
// Ports:
//   c_clk              clock; falling edge is the capture edge
//   reset[7:1]         synchronous, active-high; only reset[1] has any effect
//   res_vld, res_resp, res_data
//                      result offered this cycle (res_resp 00 is discarded)
//   res_ready          FIFO not full (from the registered count)
//   out_resp, out_data registered response pulse; 00/0 when idle
//   fifo_cnt           FIFO occupancy
//   ovf_err            sticky flag: a result was dropped because the FIFO was full
//   out_par            (RESP_PARITY_EN only) odd parity over {out_resp, out_data}
//
// Optional feature macro: RESP_PARITY_EN
module resp_drvreg
  import calc1_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic        c_clk,
  input  logic [7:1]  reset,
  input  logic        res_vld,
  input  logic [1:0]  res_resp,
  input  logic [31:0] res_data,
  output logic        res_ready,
  output logic [1:0]  out_resp,
  output logic [31:0] out_data,
  output logic [4:0]  fifo_cnt,
`ifdef RESP_PARITY_EN
  output logic        out_par,
`endif
  output logic        ovf_err
);

  localparam logic [1:0] GAP_LD = (GAP > 0) ? 2'(GAP - 1) : 2'd0;

  drv_state_e  r_state, w_nxt_state;
  logic [1:0]  r_gap, w_nxt_gap;
  logic [1:0]  r_resp, w_nxt_resp;
  logic [31:0] r_data, w_nxt_data;
  logic        r_ovf;
  logic        w_rst;
  logic        w_offer;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [1:0]  w_head_resp;
  logic [31:0] w_head_data;
  logic        w_unused_rst;

  assign w_rst        = reset[1];
  assign w_unused_rst = ^reset[7:2];

  assign w_offer = res_vld & (res_resp != RESP_NONE);
  assign w_push  = w_offer & ~w_full & ~w_rst;

  resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (c_clk),
    .i_rst   (w_rst),
    .i_push  (w_push),
    .i_resp  (res_resp),
    .i_data  (res_data),
    .i_pop   (w_pop),
    .o_resp  (w_head_resp),
    .o_data  (w_head_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_cnt   (fifo_cnt)
  );

  assign res_ready = ~w_full;
  assign out_resp  = r_resp;
  assign out_data  = r_data;
  assign ovf_err   = r_ovf;

  // WAIT counts GAP-1 down to 0. The last WAIT cycle also does the pop, so
  // exactly GAP idle cycles separate two pulses. If WAIT handed off to IDLE
  // first, IDLE would add one more idle cycle.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_gap   = r_gap;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nxt_state = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (GAP == 0) begin
          if (!w_empty) w_pop = 1'b1;
          else          w_nxt_state = ST_IDLE;
        end else begin
          w_nxt_gap   = GAP_LD;
          w_nxt_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_gap == 2'd0) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_nxt_state = ST_DRIVE;
          end else begin
            w_nxt_state = ST_IDLE;
          end
        end else begin
          w_nxt_gap = r_gap - 2'd1;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
    // The output registers hold a value only in the cycle after a pop.
    w_nxt_resp = w_pop ? w_head_resp : RESP_NONE;
    w_nxt_data = w_pop ? w_head_data : 32'd0;
  end

  always_ff @(negedge c_clk) begin
    if (w_rst) begin
      r_state <= ST_IDLE;
      r_gap   <= 2'd0;
      r_resp  <= RESP_NONE;
      r_data  <= 32'd0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_gap   <= w_nxt_gap;
      r_resp  <= w_nxt_resp;
      r_data  <= w_nxt_data;
      if (w_offer && w_full) r_ovf <= 1'b1;
    end
  end

`ifdef RESP_PARITY_EN
  logic r_par;
  // Parity is generated from the popped entry. It is 1 when the outputs are
  // idle, because the parity of all zeros is 1.
  always_ff @(negedge c_clk) begin
    if (w_rst) r_par <= 1'b1;
    else       r_par <= odd_par(w_nxt_resp, w_nxt_data);
  end
  assign out_par = r_par;
`endif

endmodule
